// File: rtl/proc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : proc_pkg
//  Description : Shared types and sizing constants for the processor front end.
//                Used by the fetch unit and by the control state machine.
//  Revision    : 1.0  initial release
// ============================================================================
package proc_pkg;

    // Default program-counter / ROM address width
    localparam int PC_W = 7;

    // Default instruction width
    localparam int IR_W = 16;

    // Fetch unit states: IDLE accepts a request, WAIT is the ROM access cycle
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } fetch_state_t;

    // Instruction opcodes decoded by the control state machine
    typedef enum logic [2:0] {
        NOOP  = 3'd0,
        STORE = 3'd1,
        LOAD  = 3'd2,
        ADD   = 3'd3,
        SUB   = 3'd4,
        HALT  = 3'd5
    } opcode_t;

endpackage : proc_pkg
`default_nettype wire

// File: rtl/program_counter.sv
`default_nettype none
// ============================================================================
//  Module      : program_counter
//  Description : Program counter register with clear-over-increment priority.
//                Increment wraps modulo 2^PC_W without any flag.
//  Revision    : 1.0  initial release
// ============================================================================
module program_counter
#(
    parameter int PC_W = proc_pkg::PC_W
)(
    input  logic            Clk,
    input  logic            Reset,
    input  logic            PC_clr,
    input  logic            PC_up,
    output logic [PC_W-1:0] PC
);

    localparam logic [PC_W-1:0] c_pc_zero = '0;
    localparam logic [PC_W-1:0] c_pc_one  = PC_W'(1);

    logic [PC_W-1:0] r_pc;

    // PC update: reset, then clear, then increment, otherwise hold
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_pc <= c_pc_zero;
        end else if (PC_clr) begin
            r_pc <= c_pc_zero;
        end else if (PC_up) begin
            r_pc <= r_pc + c_pc_one;
        end
    end

    assign PC = r_pc;

endmodule : program_counter
`default_nettype wire

// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : instruction_fetch
//  Description : Two-state fetch unit. An accepted request samples the PC,
//                the external synchronous ROM returns data one cycle later,
//                and the instruction register is loaded with a one-cycle
//                valid pulse. Requests made while busy are dropped and
//                recorded in a sticky error flag.
//  Revision    : 1.0  initial release
// ============================================================================
module instruction_fetch
#(
    parameter int PC_W = proc_pkg::PC_W,
    parameter int IR_W = proc_pkg::IR_W
)(
    input  logic            Clk,
    input  logic            Reset,
    input  logic            PC_clr,
    input  logic            IR_ld,
    input  logic            PC_up,
    input  logic [IR_W-1:0] Rom_data,
    output logic [PC_W-1:0] Rom_addr,
    output logic [PC_W-1:0] PC,
    output logic [IR_W-1:0] IR,
    output logic [PC_W-1:0] IR_pc,
    output logic            IR_valid,
    output logic            Busy,
    output logic            Ld_err
);

    import proc_pkg::*;

    fetch_state_t    r_state;
    fetch_state_t    w_next_state;
    logic            w_accept;
    logic            w_drop;
    logic            w_load;
    logic [PC_W-1:0] w_pc;
    logic [PC_W-1:0] r_fetch_addr;
    logic [IR_W-1:0] r_ir;
    logic [PC_W-1:0] r_ir_pc;
    logic            r_ir_valid;
    logic            r_ld_err;

    // Program counter runs independently of the fetch state machine
    program_counter #(
        .PC_W (PC_W)
    ) u_program_counter (
        .Clk    (Clk),
        .Reset  (Reset),
        .PC_clr (PC_clr),
        .PC_up  (PC_up),
        .PC     (w_pc)
    );

    // Fetch state register
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and request qualification; WAIT always lasts one cycle
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_drop       = 1'b0;
        w_load       = 1'b0;
        case (r_state)
            IDLE: begin
                if (IR_ld) begin
                    w_accept     = 1'b1;
                    w_next_state = WAIT;
                end
            end
            WAIT: begin
                w_load       = 1'b1;
                w_drop       = IR_ld;
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Fetch datapath: capture address on accept, load IR at the end of WAIT.
    // The ROM data seen during WAIT was addressed by the PC of the accept
    // cycle, so a PC change during WAIT cannot disturb the in-flight fetch.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_fetch_addr <= '0;
            r_ir         <= '0;
            r_ir_pc      <= '0;
            r_ir_valid   <= 1'b0;
            r_ld_err     <= 1'b0;
        end else begin
            r_ir_valid <= w_load;
            if (w_accept) begin
                r_fetch_addr <= w_pc;
            end
            if (w_load) begin
                r_ir    <= Rom_data;
                r_ir_pc <= r_fetch_addr;
            end
            if (w_drop) begin
                r_ld_err <= 1'b1;
            end
        end
    end

    assign Rom_addr = w_pc;
    assign PC       = w_pc;
    assign IR       = r_ir;
    assign IR_pc    = r_ir_pc;
    assign IR_valid = r_ir_valid;
    assign Busy     = (r_state == WAIT);
    assign Ld_err   = r_ld_err;

endmodule : instruction_fetch
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instruction_fetch
//  Description : Self-checking bench for instruction_fetch with a 1-cycle
//                synchronous ROM holding ROM[k] = 16'hA000 + k.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_instruction_fetch;

    localparam int PW = 7;
    localparam int IW = 16;

    logic          Clk;
    logic          Reset;
    logic          PC_clr;
    logic          IR_ld;
    logic          PC_up;
    logic [IW-1:0] Rom_data;
    logic [PW-1:0] Rom_addr;
    logic [PW-1:0] PC;
    logic [IW-1:0] IR;
    logic [PW-1:0] IR_pc;
    logic          IR_valid;
    logic          Busy;
    logic          Ld_err;

    int n_tests;
    int n_fail;

    instruction_fetch #(
        .PC_W (PW),
        .IR_W (IW)
    ) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .PC_clr   (PC_clr),
        .IR_ld    (IR_ld),
        .PC_up    (PC_up),
        .Rom_data (Rom_data),
        .Rom_addr (Rom_addr),
        .PC       (PC),
        .IR       (IR),
        .IR_pc    (IR_pc),
        .IR_valid (IR_valid),
        .Busy     (Busy),
        .Ld_err   (Ld_err)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic logic [IW-1:0] rom_val(input logic [PW-1:0] k);
        return 16'hA000 + {9'd0, k};
    endfunction

    // Synchronous ROM model, one cycle of read latency
    always @(posedge Clk) Rom_data <= rom_val(Rom_addr);

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle_inputs();
        Reset = 1'b0; PC_clr = 1'b0; IR_ld = 1'b0; PC_up = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        Reset = 1'b1;
        step();
        Reset = 1'b0;
    endtask

    task automatic advance_pc(input int n);
        PC_up = 1'b1;
        repeat (n) step();
        PC_up = 1'b0;
    endtask

    // Reset wins over simultaneous requests and clears every output
    task automatic test_reset();
        idle_inputs();
        advance_pc(4);
        Reset = 1'b1; IR_ld = 1'b1; PC_up = 1'b1;
        step();
        idle_inputs();
        n_tests++; if (PC !== 7'd0) begin n_fail++; $display("FAIL reset_pc: got %h want 0", PC); end
        n_tests++; if (IR !== 16'h0000) begin n_fail++; $display("FAIL reset_ir: got %h want 0000", IR); end
        n_tests++; if (IR_pc !== 7'd0) begin n_fail++; $display("FAIL reset_irpc: got %h want 0", IR_pc); end
        n_tests++; if (IR_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", IR_valid); end
        n_tests++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", Busy); end
        n_tests++; if (Ld_err !== 1'b0) begin n_fail++; $display("FAIL reset_lderr: got %b want 0", Ld_err); end
    endtask

    // Fetch with simultaneous increment, immediately after reset
    task automatic test_fetch_inc();
        do_reset();
        IR_ld = 1'b1; PC_up = 1'b1;
        step();
        idle_inputs();
        n_tests++; if (PC !== 7'd1) begin n_fail++; $display("FAIL fi_pc1: got %h want 1", PC); end
        n_tests++; if (Busy !== 1'b1) begin n_fail++; $display("FAIL fi_busy1: got %b want 1", Busy); end
        n_tests++; if (IR_valid !== 1'b0) begin n_fail++; $display("FAIL fi_valid1: got %b want 0", IR_valid); end
        step();
        n_tests++; if (IR !== 16'hA000) begin n_fail++; $display("FAIL fi_ir: got %h want A000", IR); end
        n_tests++; if (IR_pc !== 7'd0) begin n_fail++; $display("FAIL fi_irpc: got %h want 0", IR_pc); end
        n_tests++; if (IR_valid !== 1'b1) begin n_fail++; $display("FAIL fi_valid2: got %b want 1", IR_valid); end
        n_tests++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL fi_busy2: got %b want 0", Busy); end
        step();
        n_tests++; if (IR_valid !== 1'b0) begin n_fail++; $display("FAIL fi_valid3: got %b want 0", IR_valid); end
        n_tests++; if (IR !== 16'hA000) begin n_fail++; $display("FAIL fi_ir_hold: got %h want A000", IR); end
    endtask

    // Second request while busy is dropped and flagged
    task automatic test_busy_drop();
        int pulses;
        do_reset();
        advance_pc(2);
        IR_ld = 1'b1;
        step();
        n_tests++; if (Ld_err !== 1'b0) begin n_fail++; $display("FAIL bd_lderr1: got %b want 0", Ld_err); end
        n_tests++; if (Busy !== 1'b1) begin n_fail++; $display("FAIL bd_busy1: got %b want 1", Busy); end
        step();
        IR_ld = 1'b0;
        pulses = 0;
        n_tests++; if (Ld_err !== 1'b1) begin n_fail++; $display("FAIL bd_lderr2: got %b want 1", Ld_err); end
        n_tests++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL bd_busy2: got %b want 0", Busy); end
        n_tests++; if (IR !== 16'hA002) begin n_fail++; $display("FAIL bd_ir: got %h want A002", IR); end
        n_tests++; if (PC !== 7'd2) begin n_fail++; $display("FAIL bd_pc: got %h want 2", PC); end
        for (int i = 0; i < 4; i++) begin
            if (IR_valid === 1'b1) pulses++;
            step();
            n_tests++; if (Ld_err !== 1'b1) begin n_fail++; $display("FAIL bd_lderr_sticky: got %b want 1", Ld_err); end
        end
        n_tests++; if (pulses != 1) begin n_fail++; $display("FAIL bd_pulses: got %0d want 1", pulses); end
    endtask

    // PC wrap from 127 with a fetch of the pre-increment address
    task automatic test_wrap();
        do_reset();
        advance_pc(127);
        n_tests++; if (PC !== 7'd127) begin n_fail++; $display("FAIL wr_preset: got %h want 7f", PC); end
        IR_ld = 1'b1; PC_up = 1'b1;
        step();
        idle_inputs();
        n_tests++; if (PC !== 7'd0) begin n_fail++; $display("FAIL wr_pc: got %h want 0", PC); end
        step();
        n_tests++; if (IR !== 16'hA07F) begin n_fail++; $display("FAIL wr_ir: got %h want A07F", IR); end
        n_tests++; if (IR_pc !== 7'd127) begin n_fail++; $display("FAIL wr_irpc: got %h want 7f", IR_pc); end
        n_tests++; if (IR_valid !== 1'b1) begin n_fail++; $display("FAIL wr_valid: got %b want 1", IR_valid); end
    endtask

    // Clear has priority over increment
    task automatic test_clr_up();
        do_reset();
        advance_pc(5);
        n_tests++; if (PC !== 7'd5) begin n_fail++; $display("FAIL cu_preset: got %h want 5", PC); end
        PC_clr = 1'b1; PC_up = 1'b1;
        step();
        idle_inputs();
        n_tests++; if (PC !== 7'd0) begin n_fail++; $display("FAIL cu_pc: got %h want 0", PC); end
    endtask

    // Clear during WAIT leaves the in-flight fetch intact
    task automatic test_clr_wait();
        do_reset();
        advance_pc(9);
        IR_ld = 1'b1;
        step();
        IR_ld = 1'b0; PC_clr = 1'b1;
        step();
        idle_inputs();
        n_tests++; if (PC !== 7'd0) begin n_fail++; $display("FAIL cw_pc: got %h want 0", PC); end
        n_tests++; if (IR !== 16'hA009) begin n_fail++; $display("FAIL cw_ir: got %h want A009", IR); end
        n_tests++; if (IR_pc !== 7'd9) begin n_fail++; $display("FAIL cw_irpc: got %h want 9", IR_pc); end
        n_tests++; if (IR_valid !== 1'b1) begin n_fail++; $display("FAIL cw_valid: got %b want 1", IR_valid); end
    endtask

    // Reset mid-WAIT aborts the fetch; a coincident IR_ld sets no error
    task automatic test_reset_wait();
        do_reset();
        advance_pc(3);
        IR_ld = 1'b1;
        step();
        n_tests++; if (Busy !== 1'b1) begin n_fail++; $display("FAIL rw_busy_pre: got %b want 1", Busy); end
        Reset = 1'b1;
        step();
        idle_inputs();
        n_tests++; if (IR_valid !== 1'b0) begin n_fail++; $display("FAIL rw_valid: got %b want 0", IR_valid); end
        n_tests++; if (IR !== 16'h0000) begin n_fail++; $display("FAIL rw_ir: got %h want 0000", IR); end
        n_tests++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL rw_busy: got %b want 0", Busy); end
        n_tests++; if (Ld_err !== 1'b0) begin n_fail++; $display("FAIL rw_lderr: got %b want 0", Ld_err); end
        step();
        n_tests++; if (IR_valid !== 1'b0) begin n_fail++; $display("FAIL rw_valid2: got %b want 0", IR_valid); end
    endtask

    // Random traffic against a transaction-level model: each accepted fetch
    // is a record (completion cycle, address); the unit is busy for the
    // single cycle after an acceptance.
    task automatic test_random();
        int            cyc;
        int            busy_at;
        int            due_q[$];
        logic [PW-1:0] addr_q[$];
        logic [PW-1:0] m_pc;
        logic [IW-1:0] m_ir;
        logic [PW-1:0] m_irpc;
        logic          m_lderr;
        logic          m_valid;
        do_reset();
        cyc = 0; busy_at = -1;
        m_pc = '0; m_ir = '0; m_irpc = '0; m_lderr = 1'b0; m_valid = 1'b0;
        for (int i = 0; i < 400; i++) begin
            Reset  = ($urandom_range(0, 39) == 0);
            IR_ld  = 1'($urandom_range(0, 1));
            PC_up  = 1'($urandom_range(0, 1));
            PC_clr = ($urandom_range(0, 7) == 0);
            m_valid = 1'b0;
            if (Reset) begin
                m_pc = '0; m_ir = '0; m_irpc = '0; m_lderr = 1'b0;
                busy_at = -1;
                due_q.delete(); addr_q.delete();
            end else begin
                if (IR_ld) begin
                    if (busy_at == cyc) begin
                        m_lderr = 1'b1;
                    end else begin
                        due_q.push_back(cyc + 2);
                        addr_q.push_back(m_pc);
                        busy_at = cyc + 1;
                    end
                end
                if (due_q.size() > 0 && due_q[0] == cyc + 1) begin
                    m_ir   = rom_val(addr_q[0]);
                    m_irpc = addr_q[0];
                    m_valid = 1'b1;
                    void'(due_q.pop_front());
                    void'(addr_q.pop_front());
                end
                if (PC_clr)     m_pc = '0;
                else if (PC_up) m_pc = m_pc + 7'd1;
            end
            step();
            cyc++;
            n_tests++; if (PC !== m_pc) begin n_fail++; $display("FAIL rnd_pc c%0d: got %h want %h", cyc, PC, m_pc); end
            n_tests++; if (Rom_addr !== m_pc) begin n_fail++; $display("FAIL rnd_romaddr c%0d: got %h want %h", cyc, Rom_addr, m_pc); end
            n_tests++; if (Busy !== (busy_at == cyc)) begin n_fail++; $display("FAIL rnd_busy c%0d: got %b want %b", cyc, Busy, (busy_at == cyc)); end
            n_tests++; if (IR_valid !== m_valid) begin n_fail++; $display("FAIL rnd_valid c%0d: got %b want %b", cyc, IR_valid, m_valid); end
            n_tests++; if (IR !== m_ir) begin n_fail++; $display("FAIL rnd_ir c%0d: got %h want %h", cyc, IR, m_ir); end
            n_tests++; if (IR_pc !== m_irpc) begin n_fail++; $display("FAIL rnd_irpc c%0d: got %h want %h", cyc, IR_pc, m_irpc); end
            n_tests++; if (Ld_err !== m_lderr) begin n_fail++; $display("FAIL rnd_lderr c%0d: got %b want %b", cyc, Ld_err, m_lderr); end
        end
        idle_inputs();
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        idle_inputs();
        Reset = 1'b1;
        step();
        step();
        test_reset();
        test_fetch_inc();
        test_busy_drop();
        test_wrap();
        test_clr_up();
        test_clr_wait();
        test_reset_wait();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_instruction_fetch
`default_nettype wire
